// File: rtl/pixel_arbiter.sv
// Fixed-priority arbiter granting the shared VGA write port to one draw engine at a time.
// Forwards the owner's pixels with one register stage and ends a grant on done or on the watchdog.
module pixel_arbiter #(
  parameter int N_CLIENTS      = 3,
  parameter int TIMEOUT_CYCLES = 32768,
  parameter int X_MAX          = 160,
  parameter int Y_MAX          = 120
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_CLIENTS-1:0]   req,
  input  logic [8*N_CLIENTS-1:0] client_x,
  input  logic [7*N_CLIENTS-1:0] client_y,
  input  logic [3*N_CLIENTS-1:0] client_col,
  input  logic [N_CLIENTS-1:0]   client_valid,
  input  logic [N_CLIENTS-1:0]   client_done,
  output logic [N_CLIENTS-1:0]   grant,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   timeout
);

  localparam int OW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [N_CLIENTS-1:0] grant_q, grant_d;
  logic [7:0]           vga_x_q, vga_x_d;
  logic [6:0]           vga_y_q, vga_y_d;
  logic [2:0]           vga_colour_q, vga_colour_d;
  logic                 vga_plot_q, vga_plot_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  logic [15:0]          wd_q, wd_d;

  logic [7:0]    sel_x;
  logic [6:0]    sel_y;
  logic [2:0]    sel_col;
  logic          sel_valid;
  logic          sel_done;
  logic          req_any;
  logic [OW-1:0] req_idx;

  // Only the current owner's lanes are visible to the FSM.
  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_col   = '0;
    sel_valid = 1'b0;
    sel_done  = 1'b0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      if (owner_q == OW'(k)) begin
        sel_x     = client_x[8*k +: 8];
        sel_y     = client_y[7*k +: 7];
        sel_col   = client_col[3*k +: 3];
        sel_valid = client_valid[k];
        sel_done  = client_done[k];
      end
    end
  end

  // Descending scan so the lowest requesting index wins.
  always_comb begin
    req_any = 1'b0;
    req_idx = '0;
    for (int k = N_CLIENTS - 1; k >= 0; k--) begin
      if (req[k]) begin
        req_any = 1'b1;
        req_idx = OW'(k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    timeout_d    = 1'b0;
    wd_d         = wd_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          state_d = S_GRANT;
          owner_d = req_idx;
          grant_d = N_CLIENTS'(1) << req_idx;
          wd_d    = '0;
        end
      end
      S_GRANT: begin
        vga_x_d      = sel_x;
        vga_y_d      = sel_y;
        vga_colour_d = sel_col;
        vga_plot_d   = sel_valid && (int'(sel_x) < X_MAX) && (int'(sel_y) < Y_MAX);
        wd_d         = wd_q + 16'd1;
        // done takes precedence over a coincident watchdog expiry
        if (sel_done) begin
          state_d = S_RELEASE;
          grant_d = '0;
        end else if (wd_q == WD_LAST) begin
          state_d   = S_RELEASE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      grant_q      <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      wd_q         <= wd_d;
    end
  end

  assign grant      = grant_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;

endmodule
